// File: rtl/sat_engine_pkg.sv
// rtl/sat_engine_pkg.sv - shared Sat Engine types: sequencer FSM states and result codes
package sat_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_IMPLY,
        ST_DECIDE,
        ST_ANALYZE,
        ST_ANA_WAIT,
        ST_BKT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        RES_SAT     = 2'd0,
        RES_BKT     = 2'd1,
        RES_UNSAT   = 2'd2,
        RES_TIMEOUT = 2'd3
    } result_e;

endpackage

// File: rtl/sat_engine_seq_ctrl.sv
// rtl/sat_engine_seq_ctrl.sv - per-bin local search sequencer: decide -> imply -> analyze -> backtrack
import sat_engine_pkg::*;

module sat_engine_seq_ctrl #(
    parameter int WIDTH_LVL     = 16,
    parameter int WIDTH_BIN_ID  = 10,
    parameter int MAX_CONFLICTS = 255,
    parameter int WIDTH_CNT     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [WIDTH_LVL-1:0]    base_lvl_i,
    input  logic [WIDTH_BIN_ID-1:0] cur_bin_num_i,
    output logic                    done_o,
    output logic [1:0]              result_o,
    output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
    output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
    output logic                    base_lvl_en_o,
    output logic                    load_lvl_en_o,
    output logic [WIDTH_LVL-1:0]    lvl_o,
    output logic                    start_decision_o,
    input  logic                    done_decision_i,
    input  logic                    decided_any_i,
    output logic                    apply_imply_o,
    input  logic                    done_imply_i,
    input  logic                    find_conflict_i,
    output logic                    apply_analyze_o,
    input  logic                    done_analyze_i,
    input  logic [WIDTH_BIN_ID-1:0] sl_bkt_bin_i,
    input  logic [WIDTH_LVL-1:0]    sl_bkt_lvl_i,
    output logic                    apply_bkt_cur_bin_o,
    input  logic                    done_bkt_cur_bin_i
);

    localparam logic [WIDTH_CNT-1:0] MAX_CNT = WIDTH_CNT'(MAX_CONFLICTS);
    localparam bit                   LIMITED = (MAX_CONFLICTS != 0);

    state_e                  state_q, state_d;
    logic [WIDTH_LVL-1:0]    base_lvl_q, base_lvl_d;
    logic [WIDTH_BIN_ID-1:0] cur_bin_q, cur_bin_d;
    logic [WIDTH_CNT-1:0]    cnt_q, cnt_d;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_q, bkt_bin_d;
    logic [WIDTH_LVL-1:0]    bkt_lvl_q, bkt_lvl_d;
    logic [1:0]              result_q, result_d;
    logic                    dec_started_q, dec_started_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            base_lvl_q    <= '0;
            cur_bin_q     <= '0;
            cnt_q         <= '0;
            bkt_bin_q     <= '0;
            bkt_lvl_q     <= '0;
            result_q      <= '0;
            dec_started_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_lvl_q    <= base_lvl_d;
            cur_bin_q     <= cur_bin_d;
            cnt_q         <= cnt_d;
            bkt_bin_q     <= bkt_bin_d;
            bkt_lvl_q     <= bkt_lvl_d;
            result_q      <= result_d;
            dec_started_q <= dec_started_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        base_lvl_d          = base_lvl_q;
        cur_bin_d           = cur_bin_q;
        cnt_d               = cnt_q;
        bkt_bin_d           = bkt_bin_q;
        bkt_lvl_d           = bkt_lvl_q;
        result_d            = result_q;
        dec_started_d       = 1'b0;
        done_o              = 1'b0;
        base_lvl_en_o       = 1'b0;
        load_lvl_en_o       = 1'b0;
        lvl_o               = '0;
        start_decision_o    = 1'b0;
        apply_imply_o       = 1'b0;
        apply_analyze_o     = 1'b0;
        apply_bkt_cur_bin_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_lvl_d = base_lvl_i;
                    cur_bin_d  = cur_bin_num_i;
                    cnt_d      = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                base_lvl_en_o = 1'b1;
                load_lvl_en_o = 1'b1;
                lvl_o         = base_lvl_q;
                state_d       = ST_IMPLY;
            end
            ST_IMPLY: begin
                apply_imply_o = 1'b1;
                if (done_imply_i) begin
                    // Conflict is counted on the way into ANALYZE so ANA_WAIT sees the updated total.
                    if (find_conflict_i) begin
                        state_d = ST_ANALYZE;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = ST_DECIDE;
                    end
                end
            end
            ST_DECIDE: begin
                start_decision_o = !dec_started_q;
                dec_started_d    = 1'b1;
                if (done_decision_i) begin
                    if (decided_any_i) begin
                        state_d = ST_IMPLY;
                    end else begin
                        state_d   = ST_DONE;
                        result_d  = RES_SAT;
                        bkt_lvl_d = base_lvl_q;
                        bkt_bin_d = cur_bin_q;
                    end
                end
            end
            ST_ANALYZE: begin
                apply_analyze_o = 1'b1;
                if (done_analyze_i) begin
                    bkt_bin_d = sl_bkt_bin_i;
                    bkt_lvl_d = sl_bkt_lvl_i;
                    state_d   = ST_ANA_WAIT;
                end
            end
            ST_ANA_WAIT: begin
                if (bkt_lvl_q == '0 && bkt_bin_q == cur_bin_q) begin
                    state_d  = ST_DONE;
                    result_d = RES_UNSAT;
                end else if (bkt_bin_q != cur_bin_q) begin
                    state_d  = ST_DONE;
                    result_d = RES_BKT;
                end else if (LIMITED && cnt_q >= MAX_CNT) begin
                    state_d  = ST_DONE;
                    result_d = RES_TIMEOUT;
                end else begin
                    state_d = ST_BKT;
                end
            end
            ST_BKT: begin
                apply_bkt_cur_bin_o = 1'b1;
                if (done_bkt_cur_bin_i) state_d = ST_IMPLY;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign result_o  = result_q;
    assign bkt_bin_o = bkt_bin_q;
    assign bkt_lvl_o = bkt_lvl_q;

endmodule
